sha3_byte_packer: RTL and testbench
===================================

# sha3_byte_packer

Upstream feeder for the SHA-3 low-throughput core. Accepts a message as a byte stream (valid/ready, last), packs bytes big-endian into 32-bit words, and drives the core's `in`/`in_ready`/`is_last`/`byte_num` inputs. It honours `buffer_full` back-pressure, inserts the empty final word the core needs when the message length is a multiple of 4, and blocks the next message until the digest is reported ready.

## Interface

Parameters:
- `CNT_W`, default 32: width of the message byte counter (used only with `SHA3_PACKER_BYTE_CNT_EN`).

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_data`  in  8  message byte.
- `s_valid`  in  1  `s_data` is valid.
- `s_last`  in  1  this byte is the final byte of the message.
- `s_ready`  out  1  packer accepts a byte this cycle.
- `core_in`  out  32  packed word, connects to core `in`.
- `core_in_ready`  out  1  word valid, connects to core `in_ready`.
- `core_is_last`  out  1  final word, connects to core `is_last`.
- `core_byte_num`  out  2  valid bytes in the final word, connects to core `byte_num`.
- `core_buffer_full`  in  1  from core `buffer_full`.
- `core_out_ready`  in  1  from core `out_ready`.
- `busy`  out  1  a message is in progress (state ≠ IDLE).
- `msg_bytes`  out  `CNT_W`  bytes accepted in the current or last message; exists only with the macro defined.

## Operation

- A byte transfers when `s_valid && s_ready` are both high.
- States:
  - IDLE
  - ACCUM
  - EMIT
  - PAD
  - WAIT_DIGEST
- `s_ready` is high only in IDLE and ACCUM.
- IDLE/ACCUM, on a transfer:
  - Write the byte to `word[31-8*idx -: 8]`, then increment `idx` (2 bits).
  - If `idx==3` or `s_last`, go to EMIT and latch `last_q = s_last`.
  - Otherwise go to (or stay in) ACCUM.
  - The first byte of a message is always written with `idx=0` and all other bytes cleared.
- EMIT:
  - `core_in = word`; unused low bytes are 0.
  - `core_in_ready = !core_buffer_full` (combinational gate on registered state).
  - When `!core_buffer_full`, the word is taken. Clear `word` and `idx`. Then:
    - If `!last_q`, go to ACCUM.
    - If `last_q` with fewer than 4 bytes, `core_is_last=1` and `core_byte_num` = byte count (1–3); go to WAIT_DIGEST.
    - If `last_q` with 4 bytes, `core_is_last=0`; go to PAD.
- PAD:
  - Drive `core_in=0`, `core_is_last=1`, `core_byte_num=0`, `core_in_ready = !core_buffer_full`.
  - When taken, go to WAIT_DIGEST.
- WAIT_DIGEST: stay until `core_out_ready` is high, then go to IDLE. Restarting the core is the system's job, not this block's.
- `core_is_last` and `core_byte_num` are 0 whenever `core_in_ready` is 0.
- Zero-length messages are not representable on this interface and are out of scope.
- `s_last` with `s_valid` low is ignored.

## Timing

- Reset values:
  - State IDLE; `idx=0`; `word=0`.
  - `s_ready=0` while `reset` is high, then 1 in the first cycle after `reset` falls.
  - `core_in=0`, `core_in_ready=0`, `core_is_last=0`, `core_byte_num=0`, `busy=0`, `msg_bytes=0`.
- Reset mid-message drops the partial word and the counters immediately. Nothing is emitted.
- A fourth byte accepted in cycle N gives `core_in_ready=1` in cycle N+1 if `buffer_full` is low.
- Steady-state throughput is 1 word per 5 cycles, plus stall cycles while `buffer_full` is high.
- `s_ready` is low during EMIT, PAD and WAIT_DIGEST. No bytes are lost while stalled.
- If `buffer_full` rises in the EMIT cycle, `core_in_ready` is 0 and the word holds stable until `buffer_full` falls.
- `core_out_ready` seen in any state other than WAIT_DIGEST is ignored.

## Configuration

- `SHA3_PACKER_BYTE_CNT_EN` defined:
  - The `msg_bytes` port and a `CNT_W` counter are present.
  - The counter loads 1 on the first byte of a message and increments on each later accepted byte.
  - It saturates at all-ones and holds after the message until the next message's first byte.
  - Reset clears it.
- Not defined: no port, no counter. All other behaviour is identical.

## Structure

- Package `sha3_pkg` holds:
  - the state enum (IDLE, ACCUM, EMIT, PAD, WAIT_DIGEST);
  - `SHA3_LT_WORD_W=32`;
  - `SHA3_LT_BNUM_W=2`.
- One sub-module, `sha3_word_assembler`: the byte-lane write into the 32-bit word, `idx` and byte-count tracking, with clear/load controls driven by the FSM. The top level holds the FSM, handshake gating and the optional counter.

## Test plan

- Bytes 0x61,0x62,0x63 (last on 0x63), `buffer_full`=0 → one word 0x61626300, `is_last=1`, `byte_num=3`; then WAIT_DIGEST and `s_ready=0` until `core_out_ready`.
- Bytes 0x01..0x04 (last on 0x04) → word 0x01020304 with `is_last=0`, then word 0x00000000 with `is_last=1`, `byte_num=0`.
- 9-byte message with `buffer_full` held high for 7 cycles during the second EMIT → words 0x01020304, 0x05060708, 0x09000000 (`byte_num=1`); word stable during the stall; `in_ready` pulses exactly 3 times.
- Reset asserted after 2 bytes of a message → no `in_ready`; all outputs at reset values; a following 1-byte message 0xAA gives 0xAA000000 with `byte_num=1`.
- With `SHA3_PACKER_BYTE_CNT_EN`: a 9-byte message → `msg_bytes=9` held through WAIT_DIGEST; first byte of the next message → `msg_bytes=1`.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 low-throughput byte packer.
// Holds the packer state encoding and the byte-lane insert helper.
package sha3_pkg;

    localparam int SHA3_LT_WORD_W  = 32;
    localparam int SHA3_LT_BNUM_W  = 2;
    localparam int SHA3_LT_IDX_W   = 2;
    localparam int SHA3_LT_CNT_W   = 3;
    localparam logic [SHA3_LT_CNT_W-1:0] SHA3_LT_FULL_CNT = 3'd4;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ACCUM       = 3'd1,
        EMIT        = 3'd2,
        PAD         = 3'd3,
        WAIT_DIGEST = 3'd4
    } packer_state_e;

    // Big-endian lane write: lane 0 is the most significant byte.
    function automatic logic [SHA3_LT_WORD_W-1:0] lane_insert(
        input logic [SHA3_LT_WORD_W-1:0] word,
        input logic [SHA3_LT_IDX_W-1:0]  idx,
        input logic [7:0]                data
    );
        logic [SHA3_LT_WORD_W-1:0] res;
        res = word;
        case (idx)
            2'd0:    res[31:24] = data;
            2'd1:    res[23:16] = data;
            2'd2:    res[15:8]  = data;
            2'd3:    res[7:0]   = data;
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sha3_word_assembler.sv
// Packs message bytes into a 32-bit word and tracks lane index and byte count.
// The FSM in sha3_byte_packer drives the write, first-byte load and clear controls.
module sha3_word_assembler
    import sha3_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      wr_en,
    input  logic                      first,
    input  logic [7:0]                data,
    output logic [SHA3_LT_WORD_W-1:0] word,
    output logic [SHA3_LT_IDX_W-1:0]  idx,
    output logic [SHA3_LT_CNT_W-1:0]  byte_cnt
);

    logic [SHA3_LT_WORD_W-1:0] word_r;
    logic [SHA3_LT_WORD_W-1:0] word_n_s;
    logic [SHA3_LT_IDX_W-1:0]  idx_r;
    logic [SHA3_LT_IDX_W-1:0]  idx_n_s;
    logic [SHA3_LT_CNT_W-1:0]  cnt_r;
    logic [SHA3_LT_CNT_W-1:0]  cnt_n_s;

    // Next-state for word, lane index and byte count
    always_comb begin
        word_n_s = word_r;
        idx_n_s  = idx_r;
        cnt_n_s  = cnt_r;
        if (clear) begin
            word_n_s = {SHA3_LT_WORD_W{1'b0}};
            idx_n_s  = {SHA3_LT_IDX_W{1'b0}};
            cnt_n_s  = {SHA3_LT_CNT_W{1'b0}};
        end else if (wr_en) begin
            if (first) begin
                // A new message never inherits stale lanes from the previous one.
                word_n_s = lane_insert({SHA3_LT_WORD_W{1'b0}}, 2'd0, data);
                idx_n_s  = 2'd1;
                cnt_n_s  = 3'd1;
            end else begin
                word_n_s = lane_insert(word_r, idx_r, data);
                idx_n_s  = idx_r + 2'd1;
                cnt_n_s  = cnt_r + 3'd1;
            end
        end else begin
            word_n_s = word_r;
            idx_n_s  = idx_r;
            cnt_n_s  = cnt_r;
        end
    end

    // Assembly registers
    always_ff @(posedge clk) begin
        if (reset) begin
            word_r <= {SHA3_LT_WORD_W{1'b0}};
            idx_r  <= {SHA3_LT_IDX_W{1'b0}};
            cnt_r  <= {SHA3_LT_CNT_W{1'b0}};
        end else begin
            word_r <= word_n_s;
            idx_r  <= idx_n_s;
            cnt_r  <= cnt_n_s;
        end
    end

    assign word     = word_r;
    assign idx      = idx_r;
    assign byte_cnt = cnt_r;

endmodule

// File: rtl/sha3_byte_packer.sv
// Byte-stream to 32-bit word feeder for the SHA-3 low-throughput core.
// Optional message byte counter (msg_bytes port) enabled by SHA3_PACKER_BYTE_CNT_EN.
module sha3_byte_packer
    import sha3_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                s_data,
    input  logic                      s_valid,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic [SHA3_LT_WORD_W-1:0] core_in,
    output logic                      core_in_ready,
    output logic                      core_is_last,
    output logic [SHA3_LT_BNUM_W-1:0] core_byte_num,
    input  logic                      core_buffer_full,
    input  logic                      core_out_ready,
    output logic                      busy
`ifdef SHA3_PACKER_BYTE_CNT_EN
    ,
    output logic [CNT_W-1:0]          msg_bytes
`endif
);

    packer_state_e             state_r;
    logic                      last_r;
    logic                      xfer_s;
    logic                      first_s;
    logic                      emit_take_s;
    logic [SHA3_LT_WORD_W-1:0] word_s;
    logic [SHA3_LT_IDX_W-1:0]  idx_s;
    logic [SHA3_LT_CNT_W-1:0]  cnt_s;

    assign xfer_s      = s_valid && s_ready;
    assign first_s     = (state_r == IDLE);
    assign emit_take_s = (state_r == EMIT) && !core_buffer_full;

    sha3_word_assembler u_asm (
        .clk      (clk),
        .reset    (reset),
        .clear    (emit_take_s),
        .wr_en    (xfer_s),
        .first    (first_s),
        .data     (s_data),
        .word     (word_s),
        .idx      (idx_s),
        .byte_cnt (cnt_s)
    );

    // Handshake and core-side outputs, all decoded from registered state
    always_comb begin
        s_ready       = 1'b0;
        busy          = 1'b0;
        core_in       = {SHA3_LT_WORD_W{1'b0}};
        core_in_ready = 1'b0;
        core_is_last  = 1'b0;
        core_byte_num = {SHA3_LT_BNUM_W{1'b0}};
        if (reset) begin
            s_ready = 1'b0;
        end else begin
            busy = (state_r != IDLE);
            case (state_r)
                IDLE, ACCUM: begin
                    s_ready = 1'b1;
                end
                EMIT: begin
                    core_in       = word_s;
                    core_in_ready = !core_buffer_full;
                    // A full final word reports is_last on the following empty word instead.
                    if (!core_buffer_full && last_r && (cnt_s != SHA3_LT_FULL_CNT)) begin
                        core_is_last  = 1'b1;
                        core_byte_num = cnt_s[SHA3_LT_BNUM_W-1:0];
                    end else begin
                        core_is_last  = 1'b0;
                    end
                end
                PAD: begin
                    core_in_ready = !core_buffer_full;
                    core_is_last  = !core_buffer_full;
                end
                WAIT_DIGEST: begin
                    s_ready = 1'b0;
                end
                default: begin
                    s_ready = 1'b0;
                end
            endcase
        end
    end

    // Message sequencing FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            last_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, ACCUM: begin
                    if (xfer_s) begin
                        if (s_last || (!first_s && (idx_s == 2'd3))) begin
                            state_r <= EMIT;
                            last_r  <= s_last;
                        end else begin
                            state_r <= ACCUM;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                EMIT: begin
                    if (!core_buffer_full) begin
                        if (!last_r) begin
                            state_r <= ACCUM;
                        end else if (cnt_s == SHA3_LT_FULL_CNT) begin
                            state_r <= PAD;
                        end else begin
                            state_r <= WAIT_DIGEST;
                        end
                    end else begin
                        state_r <= EMIT;
                    end
                end
                PAD: begin
                    if (!core_buffer_full) begin
                        state_r <= WAIT_DIGEST;
                    end else begin
                        state_r <= PAD;
                    end
                end
                WAIT_DIGEST: begin
                    if (core_out_ready) begin
                        state_r <= IDLE;
                        last_r  <= 1'b0;
                    end else begin
                        state_r <= WAIT_DIGEST;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    last_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHA3_PACKER_BYTE_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] msg_cnt_r;

    // Saturating per-message byte counter, held until the next message starts
    always_ff @(posedge clk) begin
        if (reset) begin
            msg_cnt_r <= {CNT_W{1'b0}};
        end else if (xfer_s) begin
            if (first_s) begin
                msg_cnt_r <= CNT_ONE;
            end else if (msg_cnt_r != CNT_MAX) begin
                msg_cnt_r <= msg_cnt_r + CNT_ONE;
            end else begin
                msg_cnt_r <= msg_cnt_r;
            end
        end else begin
            msg_cnt_r <= msg_cnt_r;
        end
    end

    assign msg_bytes = msg_cnt_r;
`else
    // CNT_W only sizes the counter, which is absent in this build.
    logic [CNT_W-1:0] cnt_w_unused_s;
    assign cnt_w_unused_s = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_sha3_byte_packer.sv
// Self-checking bench for sha3_byte_packer: directed cases plus randomized messages
// checked against a message-level word model.
module tb_sha3_byte_packer;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [31:0] w;
        logic        l;
        logic [1:0]  bn;
    } word_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] core_in;
    logic        core_in_ready;
    logic        core_is_last;
    logic [1:0]  core_byte_num;
    logic        core_buffer_full;
    logic        core_out_ready;
    logic        busy;
`ifdef SHA3_PACKER_BYTE_CNT_EN
    logic [31:0] msg_bytes;
`endif

    sha3_byte_packer #(.CNT_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_last           (s_last),
        .s_ready          (s_ready),
        .core_in          (core_in),
        .core_in_ready    (core_in_ready),
        .core_is_last     (core_is_last),
        .core_byte_num    (core_byte_num),
        .core_buffer_full (core_buffer_full),
        .core_out_ready   (core_out_ready),
        .busy             (busy)
`ifdef SHA3_PACKER_BYTE_CNT_EN
        ,
        .msg_bytes        (msg_bytes)
`endif
    );

    always #5 clk = ~clk;

    word_t       exp_q[$];
    word_t       obs_q[$];
    word_t       cmp_got;
    word_t       cmp_exp;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_pulses = 0;
    bit          rand_bf_en = 1'b0;
    bit          noise_en = 1'b0;
    int          stall_at = 0;
    int          stall_len = 0;
    logic [31:0] stall_word = 32'd0;
    event        stall_ev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    task automatic finish_tb();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    // Message-level model: chunk into big-endian words, add an empty final word when len%4==0.
    function automatic void model_msg(input byte_q_t m);
        int    n;
        int    k;
        word_t e;
        n = m.size();
        for (int base = 0; base < n; base += 4) begin
            k = (n - base < 4) ? (n - base) : 4;
            e.w = 32'd0;
            for (int j = 0; j < k; j++) e.w = e.w | (32'(m[base + j]) << (24 - 8 * j));
            e.l  = (k < 4);
            e.bn = (k < 4) ? 2'(k) : 2'd0;
            exp_q.push_back(e);
        end
        if (n % 4 == 0) begin
            e.w = 32'd0; e.l = 1'b1; e.bn = 2'd0;
            exp_q.push_back(e);
        end
    endfunction

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (core_in_ready) begin
            n_pulses++;
            cmp_got = {core_in, core_is_last, core_byte_num};
            obs_q.push_back(cmp_got);
            chk("in_ready_while_full", 32'(core_buffer_full), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_in_ready", 32'(core_in_ready), 32'd0);
            end else begin
                cmp_exp = exp_q.pop_front();
                chk("word", core_in, cmp_exp.w);
                chk("is_last", 32'(core_is_last), 32'(cmp_exp.l));
                chk("byte_num", 32'(core_byte_num), 32'(cmp_exp.bn));
            end
        end else begin
            chk("is_last_gated", 32'(core_is_last), 32'd0);
            chk("byte_num_gated", 32'(core_byte_num), 32'd0);
        end
    end

    // Random back-pressure
    initial forever begin
        @(posedge clk); #1;
        if (rand_bf_en) core_buffer_full = ($urandom_range(0, 3) == 0);
    end

    // core_out_ready noise while a message is still being fed
    initial forever begin
        @(posedge clk); #1;
        if (noise_en) core_out_ready = 1'($urandom_range(0, 1));
    end

    // Directed buffer_full stall starting in the EMIT cycle
    initial forever begin
        @(stall_ev);
        #1 core_buffer_full = 1'b1;
        repeat (stall_len) begin
            @(negedge clk);
            chk("stall_word", core_in, stall_word);
            chk("stall_in_ready", 32'(core_in_ready), 32'd0);
            @(posedge clk);
        end
        #1 core_buffer_full = 1'b0;
    end

    task automatic send_raw(input byte_q_t m, input bit mark_last, input bit gaps);
        bit ok;
        for (int i = 0; i < m.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_valid = 1'b0; s_last = 1'($urandom_range(0, 1)); s_data = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            s_valid = 1'b1;
            s_data  = m[i];
            s_last  = mark_last && (i == m.size() - 1);
            ok = 1'b0;
            for (int t = 0; t < 200 && !ok; t++) begin
                @(negedge clk);
                ok = s_ready;
                if (ok && s_last) begin
                    noise_en = 1'b0;
                    core_out_ready = 1'b0;
                end
                @(posedge clk);
            end
            #1;
            if (!ok) begin
                chk("s_ready_timeout", 32'(s_ready), 32'd1);
                finish_tb();
            end
`ifdef SHA3_PACKER_BYTE_CNT_EN
            if (i == 0) chk("msg_bytes_first", msg_bytes, 32'd1);
`endif
            if (i + 1 == stall_at) -> stall_ev;
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic finish_msg(input int len);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0);
        end
        if (!ok) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            finish_tb();
        end
        @(posedge clk); #1;
        chk("wait_s_ready", 32'(s_ready), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
`ifdef SHA3_PACKER_BYTE_CNT_EN
        chk("msg_bytes_wait", msg_bytes, 32'(len));
`endif
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        chk("wait_s_ready_hold", 32'(s_ready), 32'd0);
        core_out_ready = 1'b1;
        @(posedge clk); #1;
        core_out_ready = 1'b0;
        chk("idle_s_ready", 32'(s_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
`ifdef SHA3_PACKER_BYTE_CNT_EN
        chk("msg_bytes_hold", msg_bytes, 32'(len));
`endif
    endtask

    task automatic run_msg(input byte_q_t m, input bit rnd);
        model_msg(m);
        noise_en = rnd;
        send_raw(m, 1'b1, rnd);
        finish_msg(m.size());
    endtask

    task automatic chk_obs(input string name, input int k, input logic [31:0] w,
                           input logic l, input logic [1:0] bn);
        if (obs_q.size() <= k) begin
            chk({name, "_missing"}, 32'(obs_q.size()), 32'(k + 1));
        end else begin
            chk({name, "_w"}, obs_q[k].w, w);
            chk({name, "_l"}, 32'(obs_q[k].l), 32'(l));
            chk({name, "_bn"}, 32'(obs_q[k].bn), 32'(bn));
        end
    endtask

    initial begin
        byte_q_t m;
        int      p0;
        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'd0;
        core_buffer_full = 1'b0; core_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_core_in", core_in, 32'd0);
        chk("rst_in_ready", 32'(core_in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef SHA3_PACKER_BYTE_CNT_EN
        chk("rst_msg_bytes", msg_bytes, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;

        // "abc": single partial final word
        obs_q.delete();
        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m, 1'b0);
        chk("abc_count", 32'(obs_q.size()), 32'd1);
        chk_obs("abc", 0, 32'h61626300, 1'b1, 2'd3);

        // Four bytes: full word then empty final word
        obs_q.delete();
        m = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_msg(m, 1'b0);
        chk("four_count", 32'(obs_q.size()), 32'd2);
        chk_obs("four0", 0, 32'h01020304, 1'b0, 2'd0);
        chk_obs("four1", 1, 32'h00000000, 1'b1, 2'd0);

        // Nine bytes with a 7-cycle stall on the second word
        obs_q.delete();
        p0 = n_pulses;
        stall_at = 8; stall_len = 7; stall_word = 32'h05060708;
        m = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        run_msg(m, 1'b0);
        stall_at = 0;
        chk("nine_pulses", 32'(n_pulses - p0), 32'd3);
        chk_obs("nine0", 0, 32'h01020304, 1'b0, 2'd0);
        chk_obs("nine1", 1, 32'h05060708, 1'b0, 2'd0);
        chk_obs("nine2", 2, 32'h09000000, 1'b1, 2'd1);

        // Reset in the middle of a message
        m = '{8'h11, 8'h22};
        send_raw(m, 1'b0, 1'b0);
        p0 = n_pulses;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_core_in", core_in, 32'd0);
        chk("abort_in_ready", 32'(core_in_ready), 32'd0);
        chk("abort_is_last", 32'(core_is_last), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_s_ready", 32'(s_ready), 32'd0);
`ifdef SHA3_PACKER_BYTE_CNT_EN
        chk("abort_msg_bytes", msg_bytes, 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_s_ready_back", 32'(s_ready), 32'd1);
        chk("abort_no_word", 32'(n_pulses - p0), 32'd0);
        @(posedge clk); #1;
        obs_q.delete();
        m = '{8'hAA};
        run_msg(m, 1'b0);
        chk_obs("aa", 0, 32'hAA000000, 1'b1, 2'd1);

        // Randomized messages with back-pressure, gaps and core_out_ready noise
        rand_bf_en = 1'b1;
        for (int n = 0; n < 25; n++) begin
            m.delete();
            repeat ($urandom_range(1, 13)) m.push_back(8'($urandom));
            run_msg(m, 1'b1);
        end
        rand_bf_en = 1'b0;
        @(posedge clk); #2;
        core_buffer_full = 1'b0;

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        finish_tb();
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
